// File: rtl/uart_mem_dumper.sv
// uart_mem_dumper: reads a word range from a synchronous-read memory port and
// streams each word MSB-byte-first into a byte-level UART TX interface.
// Optional trailer checksum byte enabled by defining UART_DUMP_CHECKSUM_EN.
module uart_mem_dumper #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] start_addr,
  input  logic [$clog2(DEPTH):0]   word_count,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic [INSTR_WIDTH-1:0]   rd_data,
  output logic [7:0]               tx_byte,
  output logic                     tx_en,
  input  logic                     tx_busy,
  input  logic                     tx_done
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BPW = INSTR_WIDTH / 8;
  localparam int unsigned IW  = $clog2(BPW) + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    LOAD,
    SEND,
    WAIT_DONE,
    NEXT,
    FINISH
`ifdef UART_DUMP_CHECKSUM_EN
    , CKSUM
`endif
  } state_t;

  // State entered once the last word (or an empty range) has been handled.
`ifdef UART_DUMP_CHECKSUM_EN
  localparam state_t TAIL = CKSUM;
`else
  localparam state_t TAIL = FINISH;
`endif

  state_t                 state;
  logic [CW-1:0]          remaining;
  logic [INSTR_WIDTH-1:0] shift_reg;
  logic [IW-1:0]          byte_idx;

`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0] sum;
  logic       in_cksum;

  // Running payload sum; the trailer byte itself is never accumulated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 8'h00;
    end else if (state == IDLE && start) begin
      sum <= 8'h00;
    end else if (tx_en && !in_cksum) begin
      sum <= sum + tx_byte;
    end
  end
`endif

  // Dump sequencer. A byte launch is folded into the transition that makes it
  // possible, so tx_en rises in the first cycle of the SEND phase rather than
  // one cycle later; SEND is only occupied while tx_busy holds the launch off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      remaining <= '0;
      shift_reg <= '0;
      byte_idx  <= '0;
      tx_byte   <= 8'h00;
      tx_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
      in_cksum  <= 1'b0;
`endif
    end else begin
      tx_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            rd_addr   <= start_addr;
            remaining <= word_count;
`ifdef UART_DUMP_CHECKSUM_EN
            in_cksum  <= 1'b0;
`endif
            state     <= (word_count == '0) ? TAIL : RD_WAIT;
          end
        end
        RD_WAIT: state <= LOAD;
        LOAD: begin
          shift_reg <= rd_data;
          byte_idx  <= '0;
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_byte <= rd_data[INSTR_WIDTH-1 -: 8];
            state   <= WAIT_DONE;
          end else begin
            state   <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_byte <= shift_reg[INSTR_WIDTH-1 -: 8];
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
`ifdef UART_DUMP_CHECKSUM_EN
            if (in_cksum) begin
              state <= FINISH;
            end else
`endif
            begin
              shift_reg <= {shift_reg[INSTR_WIDTH-9:0], 8'h00};
              byte_idx  <= byte_idx + IW'(1);
              if (byte_idx == IW'(BPW - 1)) begin
                state <= NEXT;
              end else if (!tx_busy) begin
                tx_en   <= 1'b1;
                tx_byte <= shift_reg[INSTR_WIDTH-9 -: 8];
              end else begin
                state <= SEND;
              end
            end
          end
        end
        NEXT: begin
          remaining <= remaining - CW'(1);
          rd_addr   <= rd_addr + AW'(1);
          state     <= (remaining == CW'(1)) ? TAIL : RD_WAIT;
        end
`ifdef UART_DUMP_CHECKSUM_EN
        CKSUM: begin
          if (!tx_busy) begin
            tx_en    <= 1'b1;
            tx_byte  <= 8'h00 - sum;
            in_cksum <= 1'b1;
            state    <= WAIT_DONE;
          end
        end
`endif
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed bench for uart_mem_dumper: memory model, UART TX responder that
// answers each tx_en with tx_done 10 cycles later, and per-scenario checks.
// Define UART_DUMP_CHECKSUM_EN for both RTL and bench to cover the trailer.
module tb_uart_mem_dumper;

  localparam int unsigned W  = 32;
  localparam int unsigned DP = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic [8:0]  word_count;
  logic        busy;
  logic        done;
  logic [7:0]  rd_addr;
  logic [W-1:0] rd_data;
  logic [7:0]  tx_byte;
  logic        tx_en;
  logic        tx_busy;
  logic        tx_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0] mem [DP];
  logic [7:0]   q_bytes[$];
  int           q_cyc[$];
  logic [7:0]   q_addr[$];
  int           n_done;
  int           done_cyc;
  int           drop_cyc;
  int           due;
  int           stable_err;
  int           en_err;
  logic         prev_busy;
  logic         prev_en;

`ifdef UART_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  uart_mem_dumper #(.INSTR_WIDTH(W), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tx_byte    (tx_byte),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory.
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Monitor and UART responder, sampling between active edges.
  always @(negedge clk) begin
    if (tx_en) begin
      if (q_bytes.size() % 4 == 0) q_addr.push_back(rd_addr);
      q_bytes.push_back(tx_byte);
      q_cyc.push_back(cyc);
      due = cyc + 10;
      if (prev_en) en_err++;
    end else if (busy && q_bytes.size() > 0 && tx_byte !== q_bytes[$]) begin
      stable_err++;
    end
    tx_done = (cyc == due);
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (prev_busy && !busy) drop_cyc = cyc;
    prev_busy = busy;
    prev_en   = tx_en;
  end

  task automatic clear_logs();
    q_bytes.delete();
    q_cyc.delete();
    q_addr.delete();
    n_done     = 0;
    done_cyc   = -1;
    drop_cyc   = -1;
    due        = -1;
    stable_err = 0;
    en_err     = 0;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [8:0] n, output int sc);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    sc         = cyc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(n_done > 0 && !busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] got_byte(input int i);
    return (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    tests++; if (tx_byte !== 8'h00) begin fails++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    tests++; if (rd_addr !== 8'h00) begin fails++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    int sc;
    logic [7:0] exp [5];
    int nb;
    exp[0] = 8'hDE; exp[1] = 8'hAD; exp[2] = 8'hBE; exp[3] = 8'hEF;
    exp[4] = 8'h00 - (8'hDE + 8'hAD + 8'hBE + 8'hEF);
    nb = CK ? 5 : 4;
    mem[0] = 32'hDEADBEEF;
    clear_logs();
    pulse_start(8'd0, 9'd1, sc);
    wait_idle(300);
    tests++; if (q_bytes.size() != nb) begin fails++; $display("FAIL single_count got %0d want %0d", q_bytes.size(), nb); end
    for (int i = 0; i < nb; i++) begin
      tests++;
      if (got_byte(i) !== exp[i]) begin fails++; $display("FAIL single_byte%0d got %h want %h", i, got_byte(i), exp[i]); end
    end
    if (q_cyc.size() >= 4) begin
      tests++; if (q_cyc[0] - sc != 3) begin fails++; $display("FAIL single_first_latency got %0d want 3", q_cyc[0] - sc); end
      tests++; if (q_cyc[1] - q_cyc[0] != 11) begin fails++; $display("FAIL single_byte_gap got %0d want 11", q_cyc[1] - q_cyc[0]); end
      tests++;
      if (done_cyc != q_cyc[nb-1] + (CK ? 12 : 13)) begin
        fails++; $display("FAIL single_done_cycle got %0d want %0d", done_cyc, q_cyc[nb-1] + (CK ? 12 : 13));
      end
    end
    tests++; if (n_done != 1) begin fails++; $display("FAIL single_done_count got %0d want 1", n_done); end
    tests++; if (drop_cyc != done_cyc + 1) begin fails++; $display("FAIL single_busy_drop got %0d want %0d", drop_cyc, done_cyc + 1); end
    tests++; if (en_err != 0) begin fails++; $display("FAIL single_tx_en_width got %0d long pulses want 0", en_err); end
  endtask

  task automatic test_wrap();
    int sc;
    int nb;
    logic [7:0] s;
    logic [7:0] e;
    mem[254] = 32'h01020304;
    mem[255] = 32'h05060708;
    mem[0]   = 32'h090A0B0C;
    nb = CK ? 13 : 12;
    clear_logs();
    pulse_start(8'd254, 9'd3, sc);
    wait_idle(800);
    tests++; if (q_bytes.size() != nb) begin fails++; $display("FAIL wrap_count got %0d want %0d", q_bytes.size(), nb); end
    s = 8'h00;
    for (int i = 0; i < 12; i++) begin
      e = 8'(i + 1);
      s = s + e;
      tests++;
      if (got_byte(i) !== e) begin fails++; $display("FAIL wrap_byte%0d got %h want %h", i, got_byte(i), e); end
    end
    if (CK) begin
      e = 8'h00 - s;
      tests++;
      if (got_byte(12) !== e) begin fails++; $display("FAIL wrap_trailer got %h want %h", got_byte(12), e); end
    end
    tests++;
    if (q_addr.size() < 3 || q_addr[0] !== 8'd254 || q_addr[1] !== 8'd255 || q_addr[2] !== 8'd0) begin
      fails++; $display("FAIL wrap_addr_seq got %p want 254,255,0", q_addr);
    end
    if (q_cyc.size() >= 5) begin
      tests++; if (q_cyc[4] - q_cyc[3] != 14) begin fails++; $display("FAIL wrap_word_gap got %0d want 14", q_cyc[4] - q_cyc[3]); end
    end
    tests++; if (n_done != 1) begin fails++; $display("FAIL wrap_done_count got %0d want 1", n_done); end
  endtask

  task automatic test_zero_count();
    int sc;
    clear_logs();
    pulse_start(8'd77, 9'd0, sc);
    wait_idle(100);
    tests++; if (q_bytes.size() != (CK ? 1 : 0)) begin fails++; $display("FAIL zero_count_bytes got %0d want %0d", q_bytes.size(), CK ? 1 : 0); end
    if (CK) begin
      tests++; if (got_byte(0) !== 8'h00) begin fails++; $display("FAIL zero_trailer got %h want 00", got_byte(0)); end
    end
    tests++; if (done_cyc - sc != (CK ? 14 : 2)) begin fails++; $display("FAIL zero_done_latency got %0d want %0d", done_cyc - sc, CK ? 14 : 2); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL zero_done_count got %0d want 1", n_done); end
  endtask

  task automatic test_tx_busy_hold();
    int sc;
    int sc2;
    int r;
    logic [7:0] exp [5];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'hD4;
    exp[4] = 8'h00 - (8'hA1 + 8'hB2 + 8'hC3 + 8'hD4);
    mem[5] = 32'hA1B2C3D4;
    clear_logs();
    tx_busy = 1'b1;
    pulse_start(8'd5, 9'd1, sc);
    repeat (8) @(negedge clk);
    pulse_start(8'd0, 9'd2, sc2);
    repeat (12) @(negedge clk);
    tests++; if (q_bytes.size() != 0) begin fails++; $display("FAIL hold_withheld got %0d launches want 0", q_bytes.size()); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_busy got %b want 1", busy); end
    tx_busy = 1'b0;
    r = cyc;
    wait_idle(300);
    if (q_cyc.size() > 0) begin
      tests++; if (q_cyc[0] != r + 1) begin fails++; $display("FAIL hold_release_latency got %0d want %0d", q_cyc[0], r + 1); end
    end
    tests++; if (q_bytes.size() != (CK ? 5 : 4)) begin fails++; $display("FAIL hold_count got %0d want %0d", q_bytes.size(), CK ? 5 : 4); end
    for (int i = 0; i < (CK ? 5 : 4); i++) begin
      tests++;
      if (got_byte(i) !== exp[i]) begin fails++; $display("FAIL hold_byte%0d got %h want %h", i, got_byte(i), exp[i]); end
    end
    tests++; if (stable_err != 0) begin fails++; $display("FAIL hold_tx_byte_stable got %0d changes want 0", stable_err); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL hold_done_count got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    int sc;
    int k;
    mem[10] = 32'h11121314;
    mem[11] = 32'h21222324;
    mem[12] = 32'h31323334;
    mem[13] = 32'h41424344;
    mem[40] = 32'hCAFEF00D;
    clear_logs();
    pulse_start(8'd10, 9'd4, sc);
    k = 0;
    while (q_bytes.size() < 5 && k < 500) begin
      @(negedge clk);
      k++;
    end
    tests++; if (q_bytes.size() != 5) begin fails++; $display("FAIL rstmid_reach_word2 got %0d bytes want 5", q_bytes.size()); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL rstmid_tx_en got %b want 0", tx_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", done); end
    tests++; if (rd_addr !== 8'd0) begin fails++; $display("FAIL rstmid_rd_addr got %0d want 0", rd_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    tests++; if (q_bytes.size() != 5) begin fails++; $display("FAIL rstmid_no_more_tx got %0d bytes want 5", q_bytes.size()); end
    clear_logs();
    pulse_start(8'd40, 9'd1, sc);
    wait_idle(300);
    tests++;
    if (got_byte(0) !== 8'hCA || got_byte(1) !== 8'hFE || got_byte(2) !== 8'hF0 || got_byte(3) !== 8'h0D) begin
      fails++; $display("FAIL rstmid_redump got %h %h %h %h want ca fe f0 0d", got_byte(0), got_byte(1), got_byte(2), got_byte(3));
    end
    tests++;
    if (q_addr.size() < 1 || q_addr[0] !== 8'd40) begin fails++; $display("FAIL rstmid_redump_addr got %p want 40", q_addr); end
  endtask

`ifdef UART_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    int sc;
    mem[3] = 32'h01020304;
    clear_logs();
    pulse_start(8'd3, 9'd1, sc);
    wait_idle(300);
    tests++; if (q_bytes.size() != 5) begin fails++; $display("FAIL cksum_count got %0d want 5", q_bytes.size()); end
    tests++; if (got_byte(4) !== 8'hF6) begin fails++; $display("FAIL cksum_trailer got %h want f6", got_byte(4)); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = 8'd0;
    word_count = 9'd0;
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    prev_busy  = 1'b0;
    prev_en    = 1'b0;
    for (int i = 0; i < DP; i++) mem[i] = '0;
    clear_logs();
    test_reset();
    test_single_word();
    test_wrap();
    test_zero_count();
    test_tx_busy_hold();
    test_reset_mid();
`ifdef UART_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_mem_dumper.md
Name: uart_mem_dumper

Overview:
- Read-back companion to the UART instruction loader.
- On a start pulse, reads a range of words from a synchronous-read memory port and serializes each word MSB-byte-first into the byte-level TX side of the UART wrapper.
- Lets the host verify memory contents over the same UART link used to load it.

Parameters:
- INSTR_WIDTH, 32, word width in bits; multiple of 8, >= 16.
- DEPTH, 256, memory depth in words; power of 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a dump.
- start_addr  input  $clog2(DEPTH)  first word address; sampled with start.
- word_count  input  $clog2(DEPTH)+1  number of words; sampled with start; range 0..DEPTH.
- busy  output  1  high from accepted start until the done pulse, inclusive.
- done  output  1  one-cycle pulse when the dump completes.
- rd_addr  output  $clog2(DEPTH)  memory read address.
- rd_data  input  INSTR_WIDTH  memory read data, valid one cycle after rd_addr.
- tx_byte  output  8  byte to the UART TX.
- tx_en  output  1  one-cycle TX launch strobe.
- tx_busy  input  1  UART TX busy.
- tx_done  input  1  one-cycle pulse when the UART finishes a byte.

Behaviour:
- Reset values: busy=0, done=0, tx_en=0, tx_byte=0, rd_addr=0. State is IDLE and all counters are cleared.
- Reset mid-dump aborts immediately; no further tx_en is issued.
- States: IDLE, RD_WAIT, LOAD, SEND, WAIT_DONE, NEXT, CKSUM (only with the optional feature), FINISH.
- IDLE:
  - On start, latch start_addr into rd_addr and word_count into the remaining counter; busy goes high.
  - If word_count==0, go to FINISH; otherwise go to RD_WAIT.
  - start is ignored whenever the block is not in IDLE.
- RD_WAIT: one cycle of synchronous-read latency, then LOAD.
- LOAD: capture rd_data into the shift register, set byte index=0, go to SEND.
- SEND:
  - When tx_busy==0, drive tx_byte = shift_reg[INSTR_WIDTH-1 -: 8] and pulse tx_en for exactly one cycle, then go to WAIT_DONE.
  - While tx_busy==1, hold in SEND.
- WAIT_DONE:
  - tx_byte is held stable.
  - On tx_done, shift the register left 8 bits and increment the byte index.
  - If the index reaches INSTR_WIDTH/8, go to NEXT; otherwise go to SEND.
- NEXT:
  - Decrement remaining and set rd_addr = rd_addr+1 modulo DEPTH; wrap from DEPTH-1 to 0 is legal.
  - If remaining becomes 0, go to FINISH (CKSUM when enabled); otherwise go to RD_WAIT.
- FINISH: pulse done for one cycle, drop busy in the following cycle, return to IDLE.
- Latency:
  - With tx_busy low, the first tx_en occurs 3 cycles after the start cycle.
  - Per word: 3 cycles of read overhead, plus per byte 1 cycle from tx_done to the next tx_en.
- Byte order: for 32-bit words, bits [31:24] are sent first and [7:0] last. This matches the loader's shift-in order, so a dump round-trips byte-identical.
- A tx_done arriving outside WAIT_DONE is ignored.
- rd_addr changes only in IDLE (on start) and in NEXT.

Optional Feature:
- Macro: UART_DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every payload byte at its tx_en.
  - After the last word, CKSUM sends one extra byte = two's complement of the sum, using the same SEND/WAIT_DONE handshake, before FINISH.
  - With word_count==0, a single 0x00 byte is sent.
  - The sum clears on each accepted start.
- Undefined: no CKSUM state; no trailing byte.

Test Plan:
- Memory[0]=0xDEADBEEF, start_addr=0, word_count=1, tx_busy low, tx_done 10 cycles after each tx_en -> bytes DE,AD,BE,EF in order; first tx_en 3 cycles after start; done pulses once; busy drops afterward.
- start_addr=254, word_count=3, mem[254]=0x01020304, mem[255]=0x05060708, mem[0]=0x090A0B0C -> rd_addr sequence 254,255,0; 12 bytes 01..0C in order.
- word_count=0 -> no tx_en (or a single 0x00 with UART_DUMP_CHECKSUM_EN); done pulses 2 cycles after start.
- tx_busy held high 20 cycles after LOAD -> tx_en withheld until tx_busy falls; tx_byte stable until tx_done; a second start during the dump is ignored.
- rst asserted in the middle of word 2 of a 4-word dump -> tx_en, busy, done, rd_addr all 0 immediately; a new start afterward dumps correctly from its own start_addr.
- UART_DUMP_CHECKSUM_EN, word 0x01020304 -> payload 01,02,03,04, then trailer 0xF6 (sum 0x0A negated).
